// File: rtl/alu_resp_framer.sv
// alu_resp_framer: turns one ALU result word (opcode echo, result, error flag)
// into a framed byte stream for the UART TX FIFO:
//   OP, STAT, LEN_LO, LEN_HI, PAYLOAD[0..NBYTES-1] (LSB first)
// The payload is dropped when the error flag is set.
// Optional macro ALU_FRAMER_CHKSUM_EN appends an XOR checksum byte (CHK).
// tx_data_o is registered; the first byte is valid the cycle after accept.
module alu_resp_framer #(
    parameter int RESULT_WIDTH_P = 32,  // multiple of 8, 8..64
    parameter int CNT_WIDTH_P    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    input  logic [7:0]                res_opcode_i,
    input  logic [RESULT_WIDTH_P-1:0] res_data_i,
    input  logic                      res_err_i,
    output logic [7:0]                tx_data_o,
    output logic                      tx_valid_o,
    input  logic                      tx_ready_i,
    output logic                      busy_o,
    output logic [CNT_WIDTH_P-1:0]    pkt_count_o
);

    localparam int NBYTES = RESULT_WIDTH_P / 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);

`ifdef ALU_FRAMER_CHKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif

    localparam logic [15:0] LEN_OK  = 16'(4 + NBYTES + CHK_BYTES);
    localparam logic [15:0] LEN_ERR = 16'(4 + CHK_BYTES);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    // state_q names the byte currently presented on tx_data_o
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR_OP  = 3'd1;
    localparam logic [2:0] ST_HDR_STAT = 3'd2;
    localparam logic [2:0] ST_LEN_LO  = 3'd3;
    localparam logic [2:0] ST_LEN_HI  = 3'd4;
    localparam logic [2:0] ST_PAYLOAD = 3'd5;
`ifdef ALU_FRAMER_CHKSUM_EN
    localparam logic [2:0] ST_CHK     = 3'd6;
`endif

    logic [2:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic [CNT_WIDTH_P-1:0]    cnt_q, cnt_d;
    logic [RESULT_WIDTH_P-1:0] data_q;
    logic                      err_q;
    logic                      capture;
    logic                      xfer;
    logic                      body_done;
    logic [15:0]               len_w;
`ifdef ALU_FRAMER_CHKSUM_EN
    logic [7:0]                chk_q, chk_d;
`endif

    // Select payload byte i of the captured result (byte 0 = LSB)
    function automatic logic [7:0] byte_sel(input logic [RESULT_WIDTH_P-1:0] w,
                                            input logic [IDX_W-1:0] i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            if (i == IDX_W'(k)) b = w[k*8 +: 8];
        end
        return b;
    endfunction

    assign xfer        = tx_valid_q && tx_ready_i;
    assign len_w       = err_q ? LEN_ERR : LEN_OK;
    assign res_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign pkt_count_o = cnt_q;

    // Next-state logic: on each transfer advance and load the next byte
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        body_done  = 1'b0;
`ifdef ALU_FRAMER_CHKSUM_EN
        chk_d      = chk_q;
        if (xfer) chk_d = chk_q ^ tx_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (res_valid_i) begin
                    capture    = 1'b1;
                    state_d    = ST_HDR_OP;
                    tx_data_d  = res_opcode_i;
                    tx_valid_d = 1'b1;
                    idx_d      = '0;
`ifdef ALU_FRAMER_CHKSUM_EN
                    chk_d      = 8'h00;
`endif
                end
            end
            ST_HDR_OP: begin
                if (xfer) begin
                    state_d   = ST_HDR_STAT;
                    tx_data_d = {7'b0, err_q};
                end
            end
            ST_HDR_STAT: begin
                if (xfer) begin
                    state_d   = ST_LEN_LO;
                    tx_data_d = len_w[7:0];
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    state_d   = ST_LEN_HI;
                    tx_data_d = len_w[15:8];
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    if (err_q) begin
                        body_done = 1'b1;
                    end else begin
                        state_d   = ST_PAYLOAD;
                        tx_data_d = byte_sel(data_q, '0);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (idx_q == IDX_LAST) begin
                        body_done = 1'b1;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_data_d = byte_sel(data_q, idx_d);
                    end
                end
            end
`ifdef ALU_FRAMER_CHKSUM_EN
            ST_CHK: begin
                if (xfer) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                    cnt_d      = cnt_q + CNT_WIDTH_P'(1);
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // Last header/payload byte just left: append CHK or close the frame
        if (body_done) begin
`ifdef ALU_FRAMER_CHKSUM_EN
            state_d   = ST_CHK;
            tx_data_d = chk_q ^ tx_data_q;
`else
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            cnt_d      = cnt_q + CNT_WIDTH_P'(1);
`endif
        end
    end

    // Control and output registers, cleared immediately on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            cnt_q      <= '0;
`ifdef ALU_FRAMER_CHKSUM_EN
            chk_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cnt_q      <= cnt_d;
`ifdef ALU_FRAMER_CHKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    // Result word capture; only meaningful while a frame is in flight
    always_ff @(posedge clk_i) begin
        if (capture) begin
            data_q <= res_data_i;
            err_q  <= res_err_i;
        end
    end

endmodule

// File: tb/tb_alu_resp_framer.sv
// Bench for alu_resp_framer: directed and randomized frames compared against
// a frame-level reference model (byte list built from the frame rules).
module tb_alu_resp_framer;

    localparam int RW = 32;
    localparam int CW = 4;
    localparam int NB = RW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [7:0]    res_op = 8'h00;
    logic [RW-1:0] res_data = '0;
    logic          res_err = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic [CW-1:0] pkt_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int model_cnt = 0;

    logic [7:0] rx_q[$];
    int         rxc_q[$];
    int         acc_q[$];
    logic [7:0] exp_q[$];

    alu_resp_framer #(.RESULT_WIDTH_P(RW), .CNT_WIDTH_P(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .res_valid_i(res_valid), .res_ready_o(res_ready),
        .res_opcode_i(res_op), .res_data_i(res_data), .res_err_i(res_err),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .busy_o(busy), .pkt_count_o(pkt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepts and byte transfers that will happen at the next edge
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) acc_q.push_back(cyc);
        if (rst_n && tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            rxc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, optional payload, optional XOR checksum
    function automatic void model_append(input logic [7:0] op, input logic [RW-1:0] d,
                                         input logic e);
        int len;
        logic [7:0] b[$];
        logic [7:0] x;
        len = 4 + (e ? 0 : NB);
`ifdef ALU_FRAMER_CHKSUM_EN
        len = len + 1;
`endif
        b.push_back(op);
        b.push_back(e ? 8'h01 : 8'h00);
        b.push_back(8'(len % 256));
        b.push_back(8'(len / 256));
        if (!e) for (int i = 0; i < NB; i++) b.push_back(8'(d >> (8 * i)));
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
`ifdef ALU_FRAMER_CHKSUM_EN
        b.push_back(x);
`endif
        foreach (b[i]) exp_q.push_back(b[i]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input string tag, input int n, input bit rnd);
        int b;
        b = 0;
        while (rx_q.size() < n && b < 400) begin
            step();
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            b++;
        end
        tx_ready = 1'b1;
        check({tag, "_nbytes"}, rx_q.size(), n);
    endtask

    task automatic send(input logic [7:0] op, input logic [RW-1:0] d, input logic e,
                        output int acc);
        int n;
        int b;
        res_op = op; res_data = d; res_err = e; res_valid = 1'b1;
        n = acc_q.size();
        b = 0;
        while (acc_q.size() == n && b < 400) begin
            step();
            b++;
        end
        res_valid = 1'b0;
        res_op = 8'($urandom); res_data = RW'($urandom); res_err = 1'($urandom);
        check("accept", acc_q.size() > n, 1);
        acc = (acc_q.size() > n) ? acc_q[$] : -100;
    endtask

    task automatic compare_bytes(input string tag, input bit timing, input int acc);
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check({tag, "_byte"}, rx_q[i], exp_q[i]);
            if (timing) check({tag, "_cyc"}, rxc_q[i], acc + 1 + i);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] op, input logic [RW-1:0] d,
                             input logic e, input bit timing);
        int acc;
        rx_q.delete(); rxc_q.delete(); exp_q.delete();
        model_append(op, d, e);
        send(op, d, e, acc);
        wait_bytes(tag, exp_q.size(), !timing);
        compare_bytes(tag, timing, acc);
        model_cnt = (model_cnt + 1) % (1 << CW);
        check({tag, "_cnt"}, pkt_count, model_cnt);
        check({tag, "_ready"}, res_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, tx_valid, 0);
    endtask

    initial begin
        int acc;
        int ends;
        int flen[17];
        logic [7:0] lit[$];

        // Reset state
        step(); step();
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 8'h00);
        check("rst_cnt", pkt_count, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", res_ready, 1);
        rst_n = 1'b1;
        step();

        // Normal frame against the literal byte sequence
        run_frame("normal", 8'h03, 32'h12345678, 1'b0, 1'b1);
`ifdef ALU_FRAMER_CHKSUM_EN
        lit = '{8'h03, 8'h00, 8'h09, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h02};
`else
        lit = '{8'h03, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`endif
        check("normal_lit_len", rx_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < rx_q.size(); i++) check("normal_lit", rx_q[i], lit[i]);

        // Error frame: header only
        run_frame("err", 8'h07, RW'($urandom), 1'b1, 1'b1);
        check("err_stat", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h01);

        // Backpressure while LEN_LO is presented
        rx_q.delete(); rxc_q.delete(); exp_q.delete();
        res_data = RW'($urandom);
        model_append(8'h5A, res_data, 1'b0);
        send(8'h5A, res_data, 1'b0, acc);
        step(); step();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", tx_valid, 1);
            check("bp_data", tx_data, exp_q[2]);
            step();
        end
        tx_ready = 1'b1;
        wait_bytes("bp", exp_q.size(), 1'b0);
        compare_bytes("bp", 1'b0, acc);
        model_cnt = (model_cnt + 1) % (1 << CW);
        check("bp_cnt", pkt_count, model_cnt);

        // Random frames with random FIFO backpressure
        for (int f = 0; f < 6; f++) begin
            run_frame("rand", 8'($urandom), RW'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0);
        end

        // Reset mid-frame after two bytes
        rx_q.delete(); rxc_q.delete(); exp_q.delete();
        model_append(8'hC3, 32'hA1B2C3D4, 1'b0);
        send(8'hC3, 32'hA1B2C3D4, 1'b0, acc);
        step(); step();
        check("mid_nbytes", rx_q.size(), 2);
        rst_n = 1'b0;
        #1;
        check("mid_valid", tx_valid, 0);
        check("mid_ready", res_ready, 1);
        check("mid_busy", busy, 0);
        check("mid_cnt", pkt_count, 0);
        model_cnt = 0;
        step();
        rst_n = 1'b1;
        step();
        run_frame("fresh", 8'h9E, RW'($urandom), 1'b0, 1'b1);

        // Back-to-back frames with res_valid held high, counter wrap
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        rx_q.delete(); rxc_q.delete(); exp_q.delete(); acc_q.delete();
        res_op = 8'($urandom); res_data = RW'($urandom); res_err = ($urandom_range(0, 3) == 0);
        model_append(res_op, res_data, res_err);
        flen[0] = exp_q.size();
        res_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            int b;
            b = 0;
            while (acc_q.size() <= k && b < 400) begin
                step();
                b++;
            end
            check("b2b_accept", acc_q.size() > k, 1);
            ends = exp_q.size();
            if (k < 16) begin
                res_op = 8'($urandom); res_data = RW'($urandom);
                res_err = ($urandom_range(0, 3) == 0);
                model_append(res_op, res_data, res_err);
                flen[k+1] = exp_q.size() - ends;
            end else begin
                res_valid = 1'b0;
            end
            wait_bytes("b2b", ends, 1'b0);
            check("b2b_cnt", pkt_count, (k + 1) % 16);
        end
        for (int k = 1; k < 17 && k < acc_q.size(); k++) begin
            check("b2b_gap", acc_q[k] - acc_q[k-1], flen[k-1] + 1);
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) check("b2b_byte", rx_q[i], exp_q[i]);
        check("b2b_total", rx_q.size(), exp_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
